// File: rtl/counter_sweep_ctrl.sv
// rtl/counter_sweep_ctrl.sv - triangle-sweep sequencer around an up/down counter
//
// Purpose: on an accepted start, drives count from lo up to hi, back down to lo,
//          and so on for a programmed number of monotonic legs.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             sweep request, sampled only while idle
//   lo, hi, legs      sweep configuration, latched on an accepted start
//   pause             freezes an active sweep while high
//   count             registered counter value
//   up_down           direction of the next step (1 = up)
//   busy              sweep in progress
//   done              one-cycle pulse after the final step
//   err               one-cycle pulse on a rejected start (lo >= hi or legs == 0)
module counter_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int LEG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [LEG_W-1:0] legs,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             up_down,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic [WIDTH-1:0] lo_q, lo_n;
    logic [WIDTH-1:0] hi_q, hi_n;
    logic [LEG_W-1:0] legs_left, legs_n;
    logic             up_down_n;
    logic             busy_n;
    logic             done_n;
    logic             err_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            up_down   <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            legs_left <= '0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            up_down   <= up_down_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            lo_q      <= lo_n;
            hi_q      <= hi_n;
            legs_left <= legs_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        up_down_n = up_down;
        busy_n    = busy;
        done_n    = 1'b0;
        err_n     = 1'b0;
        lo_n      = lo_q;
        hi_n      = hi_q;
        legs_n    = legs_left;

        case (state)
            IDLE: begin
                if (start) begin
                    if ((lo < hi) && (legs != '0)) begin
                        lo_n      = lo;
                        hi_n      = hi;
                        legs_n    = legs;
                        count_n   = lo;
                        up_down_n = 1'b1;
                        busy_n    = 1'b1;
                        state_n   = UP;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            UP: begin
                if (!pause) begin
                    count_n = count + WIDTH'(1);
                    // Ending the leg one step early keeps count inside
                    // [lo_q, hi_q] even when hi_q is the all-ones value.
                    if (count == hi_q - WIDTH'(1)) begin
                        legs_n = legs_left - LEG_W'(1);
                        if (legs_left == LEG_W'(1)) begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n   = DOWN;
                            up_down_n = 1'b0;
                        end
                    end
                end
            end

            DOWN: begin
                if (!pause) begin
                    count_n = count - WIDTH'(1);
                    if (count == lo_q + WIDTH'(1)) begin
                        legs_n = legs_left - LEG_W'(1);
                        if (legs_left == LEG_W'(1)) begin
                            state_n = DONE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            state_n   = UP;
                            up_down_n = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
Sequencer that owns an up/down counter and drives it in triangle sweeps between programmable bounds lo and hi for a programmed number of legs.
It sits between a host or test controller and logic that consumes the count value, such as address or stimulus generation.
It uses a start/busy/done handshake, has a pause input, and flags illegal configurations.

Parameters:
WIDTH, 4, width of count, lo and hi
LEG_W, 4, width of the legs input and the internal legs-remaining counter

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  reset; synchronous, active-high
start  input  1  request a sweep; sampled only in IDLE
lo  input  WIDTH  lower bound; latched on accepted start
hi  input  WIDTH  upper bound; latched on accepted start
legs  input  LEG_W  number of monotonic legs (up or down runs) to perform
pause  input  1  freezes the sweep while high
count  output  WIDTH  counter value, registered
up_down  output  1  direction of the next step: 1 = up, 0 = down
busy  output  1  high from accepted start until the final step completes
done  output  1  single-cycle pulse after the final step
err  output  1  single-cycle pulse on a rejected start

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, count=0, up_down=1, busy=0, done=0, err=0, internal lo_q/hi_q/legs_left=0. Reset wins over every other input. Reset mid-sweep aborts the sweep with no done pulse; count=0 after that edge.
- States: IDLE, UP, DOWN, DONE.
- IDLE, start=1 with lo<hi and legs!=0:
  - latch lo_q, hi_q, legs_left=legs
  - count<=lo, up_down<=1, busy<=1, next state UP
- IDLE, start=1 with lo>=hi or legs==0:
  - err<=1 for one cycle, state stays IDLE, count and up_down unchanged
- IDLE, start=0: count holds its last value.
- UP, pause=0:
  - count<=count+1
  - if count==hi_q-1 (final step of the leg): legs_left<=legs_left-1
    - if legs_left==1: next state DONE, busy<=0, done<=1
    - else: next state DOWN, up_down<=0
- DOWN, pause=0: mirror of UP. count<=count-1; leg ends when count==lo_q+1; on a non-final leg, next state UP and up_down<=1.
- pause=1 in UP or DOWN: count, state, up_down and legs_left all hold. pause has no effect in IDLE or DONE.
- DONE: done<=0, next state IDLE. count holds its final value: hi_q if legs is odd, lo_q if legs is even.
- start while busy or in DONE: ignored, with no err pulse.
- lo/hi/legs changes after acceptance: no effect until the next accepted start.
- Latency:
  - start sampled at edge k: count=lo and busy=1 after edge k.
  - first step at edge k+1.
  - with no pauses, the final step lands at edge k+legs*(hi-lo), done is high during the following cycle, and IDLE is reached one edge later.
- Invariants while busy:
  - every unpaused cycle changes count by exactly +1 or -1
  - lo_q <= count <= hi_q, so count never wraps; lo=0, hi=2^WIDTH-1 is legal
  - only one of done and err is high in any cycle
  - busy and done are never high in the same cycle

Test Plan:
- Basic sweep: lo=2, hi=5, legs=3, start for 1 cycle -> count 2,3,4,5,4,3,2,3,4,5 on consecutive edges; busy high for 9 steps; up_down 0 during the 5..2 leg; done pulses once; count stays 5 in IDLE.
- Illegal config: lo=6, hi=6, start -> err=1 for exactly 1 cycle, busy=0, count unchanged. Repeat with lo=1, hi=4, legs=0 -> same response.
- Pause mid-leg: lo=0, hi=3, legs=2; hold pause for 4 cycles at count=2 while going up -> count frozen at 2 and up_down=1 throughout; sequence then resumes 3,2,1,0; done after 6 steps total.
- Full range: lo=0, hi=15, legs=2 -> 0..15..0 with no wrap; 30 steps; final count=0.
- Reset mid-sweep at count=4 in DOWN -> after the reset edge count=0, busy=0, up_down=1, no done pulse; a new start is accepted cleanly afterwards.
- start held high through a whole sweep: lo=3, hi=4, legs=1 -> second sweep begins only after DONE→IDLE, and no err pulses occur.
